// File: rtl/fft_pkg.sv
// Shared sizes, sample/lane types and FSM state encodings for the FFT input buffer.
package fft_pkg;

  localparam int unsigned IO_BITS    = 20;
  localparam int unsigned TOTAL_BITS = 30;
  localparam int unsigned PAD_BITS   = TOTAL_BITS - IO_BITS;
  localparam int unsigned N_POINTS   = 256;
  localparam int unsigned LANES      = 8;
  localparam int unsigned BEATS      = 32;
  localparam int unsigned ROW_BITS   = 5;
  localparam int unsigned LANE_BITS  = 3;
  localparam int unsigned CNT_BITS   = 8;

  typedef logic signed [IO_BITS-1:0]    io_t;
  typedef logic signed [TOTAL_BITS-1:0] lane_t;

  // One complex serial sample as stored in a lane memory.
  typedef struct packed {
    io_t re;
    io_t im;
  } sample_t;

  typedef enum logic {W_IDLE, W_FILL}  wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  // Place the I/O sample in the top bits of a datapath lane.
  function automatic lane_t widen(input io_t x);
    return lane_t'({x, {PAD_BITS{1'b0}}});
  endfunction

endpackage

// File: rtl/fft_input_buffer_if.sv
// Serial sample input and 8-lane parallel output bundle of the FFT input buffer.
interface fft_input_buffer_if;
  import fft_pkg::*;

  logic  startin;
  io_t   realin;
  io_t   imagin;
  logic  startout;
  logic  validout;
  lane_t real_out_0, real_out_1, real_out_2, real_out_3;
  lane_t real_out_4, real_out_5, real_out_6, real_out_7;
  lane_t imag_out_0, imag_out_1, imag_out_2, imag_out_3;
  lane_t imag_out_4, imag_out_5, imag_out_6, imag_out_7;

  modport master (
    output startin, realin, imagin,
    input  startout, validout,
    input  real_out_0, real_out_1, real_out_2, real_out_3,
    input  real_out_4, real_out_5, real_out_6, real_out_7,
    input  imag_out_0, imag_out_1, imag_out_2, imag_out_3,
    input  imag_out_4, imag_out_5, imag_out_6, imag_out_7
  );

  modport slave (
    input  startin, realin, imagin,
    output startout, validout,
    output real_out_0, real_out_1, real_out_2, real_out_3,
    output real_out_4, real_out_5, real_out_6, real_out_7,
    output imag_out_0, imag_out_1, imag_out_2, imag_out_3,
    output imag_out_4, imag_out_5, imag_out_6, imag_out_7
  );

endinterface

// File: rtl/fft_in_lane_mem.sv
// One lane of the ping-pong frame store: 2 banks x 32 rows of complex samples.
module fft_in_lane_mem
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic                wbank,
  input  logic [ROW_BITS-1:0] wrow,
  input  sample_t             wdata,
  input  logic                rbank,
  input  logic [ROW_BITS-1:0] rrow,
  output sample_t             rdata_c
);

  sample_t mem [2*BEATS];

  // Synchronous write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbank, wrow}] <= wdata;
    end
  end

  // Combinational read so the drain FSM can register a row in the same cycle.
  assign rdata_c = mem[{rbank, rrow}];

endmodule

// File: rtl/fft_input_buffer.sv
// Serial-to-parallel FFT front end: fills one bank with 256 samples, drains the other as 32 beats of 8 lanes.
module fft_input_buffer
  import fft_pkg::*;
(
  input logic         clk,
  input logic         reset,
  fft_input_buffer_if.slave bus
);

  wstate_t               w_state;
  logic [CNT_BITS-1:0]   wcnt;
  logic                  wbank;
  rstate_t               r_state;
  logic [ROW_BITS-1:0]   rcnt;
  logic                  rbank;
  logic                  startout;
  logic                  validout;
  lane_t                 re_q [LANES];
  lane_t                 im_q [LANES];

  logic [CNT_BITS-1:0]   widx_c;
  logic [LANE_BITS-1:0]  wlane_c;
  logic [ROW_BITS-1:0]   wrow_c;
  logic                  wen_c;
  logic                  frame_ready_c;
  sample_t               wsample_c;
  sample_t               rdata_c [LANES];

  // Address decode: first half of the frame goes to even lanes, second half to odd lanes.
  assign widx_c        = bus.startin ? CNT_BITS'(0) : wcnt;
  assign wlane_c       = {widx_c[1:0], widx_c[7]};
  assign wrow_c        = widx_c[6:2];
  assign wen_c         = bus.startin || (w_state == W_FILL);
  assign wsample_c     = '{re: bus.realin, im: bus.imagin};
  // A restart on the last sample abandons the frame instead of completing it.
  assign frame_ready_c = (w_state == W_FILL) && !bus.startin && (wcnt == CNT_BITS'(N_POINTS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fft_in_lane_mem u_mem (
      .clk     (clk),
      .we      (wen_c && (wlane_c == LANE_BITS'(l))),
      .wbank   (wbank),
      .wrow    (wrow_c),
      .wdata   (wsample_c),
      .rbank   (rbank),
      .rrow    (rcnt),
      .rdata_c (rdata_c[l])
    );
  end

  // Write FSM: sample counter and bank toggle on frame completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      wcnt    <= '0;
      wbank   <= 1'b0;
    end else if (bus.startin) begin
      w_state <= W_FILL;
      wcnt    <= CNT_BITS'(1);
    end else if (w_state == W_FILL) begin
      wcnt <= wcnt + CNT_BITS'(1);
      if (wcnt == CNT_BITS'(N_POINTS - 1)) begin
        wbank   <= ~wbank;
        w_state <= W_IDLE;
      end
    end
  end

  // Read FSM: latch the completed bank and register one row of all lanes per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= R_IDLE;
      rcnt     <= '0;
      rbank    <= 1'b0;
      startout <= 1'b0;
      validout <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        re_q[l] <= '0;
        im_q[l] <= '0;
      end
    end else begin
      startout <= 1'b0;
      validout <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (frame_ready_c) begin
            rbank   <= wbank;
            rcnt    <= '0;
            r_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          for (int l = 0; l < LANES; l++) begin
            re_q[l] <= widen(rdata_c[l].re);
            im_q[l] <= widen(rdata_c[l].im);
          end
          validout <= 1'b1;
          startout <= (rcnt == '0);
          rcnt     <= rcnt + ROW_BITS'(1);
          if (rcnt == ROW_BITS'(BEATS - 1)) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Map the registered lanes onto the bus.
  assign bus.startout   = startout;
  assign bus.validout   = validout;
  assign bus.real_out_0 = re_q[0];
  assign bus.real_out_1 = re_q[1];
  assign bus.real_out_2 = re_q[2];
  assign bus.real_out_3 = re_q[3];
  assign bus.real_out_4 = re_q[4];
  assign bus.real_out_5 = re_q[5];
  assign bus.real_out_6 = re_q[6];
  assign bus.real_out_7 = re_q[7];
  assign bus.imag_out_0 = im_q[0];
  assign bus.imag_out_1 = im_q[1];
  assign bus.imag_out_2 = im_q[2];
  assign bus.imag_out_3 = im_q[3];
  assign bus.imag_out_4 = im_q[4];
  assign bus.imag_out_5 = im_q[5];
  assign bus.imag_out_6 = im_q[6];
  assign bus.imag_out_7 = im_q[7];

endmodule
